// File: rtl/ifetch_bridge_pkg.sv
// ifetch_bridge_pkg
//   Shared definitions for the instruction-fetch bridge: fetch capacity,
//   AdEL exception code, boot/exception vector addresses, the control FSM
//   state type and the output-buffer entry layout.
package ifetch_bridge_pkg;

    localparam int unsigned FETCH_CAP  = 2;
    localparam logic [4:0]  EXC_ADEL   = 5'h04;
    localparam logic [31:0] RESET_ADDR = 32'hbfc0_0000;
    localparam logic [31:0] EXEC_ADDR  = 32'hbfc0_0380;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_bridge_if.sv
// ifetch_bridge_if
//   Bundles the PC-stage, SRAM-like instruction bus and decode-stage
//   handshakes of the fetch bridge.
//   master: bridge side (drives pc_ready, inst_req/addr, id_*)
//   slave : environment side (PC stage, memory, decode)
interface ifetch_bridge_if;

    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        input  pc_addr, pc_valid, flush,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  id_ready,
        output pc_ready, inst_req, inst_addr,
        output id_valid, id_pc, id_inst, id_adel
    );

    modport slave (
        output pc_addr, pc_valid, flush,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output id_ready,
        input  pc_ready, inst_req, inst_addr,
        input  id_valid, id_pc, id_inst, id_adel
    );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo
//   Two-entry FIFO with synchronous reset and synchronous clear.
//   clk/reset : clock, synchronous active-high reset
//   clear     : drop all entries (takes priority over push/pop)
//   push/wdata: enqueue; accepted when full only together with a pop
//   pop       : dequeue the head entry
//   rdata     : head entry (registered storage, no bypass)
//   count     : number of valid entries (0..2)
module ifetch_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != 2'd0);
        // When full, the slot being written is the one popped this cycle.
        do_push  = push & ((count_q != 2'd2) | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            mem_d    = '{default: '0};
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_bridge.sv
// ifetch_bridge
//   Bridges the PC stage to an SRAM-like instruction bus and buffers
//   returned instructions for decode. At most two fetches are in flight or
//   buffered at once. A flush discards everything; responses to requests
//   that were outstanding at the flush are counted off in DRAIN.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : ifetch_bridge_if.master (PC stage, instruction bus, decode)
module ifetch_bridge
    import ifetch_bridge_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    ifetch_bridge_if.master bus
);

    state_e       state_q, state_d;
    logic [1:0]   inflight_q, inflight_d;
    logic [1:0]   cancel_q, cancel_d;

    logic [1:0]   pend_count;
    logic [31:0]  pend_head;
    logic [1:0]   buf_count;
    fetch_entry_t buf_head;
    fetch_entry_t buf_wdata;

    logic aligned, credit_ok, inst_req, req_acc, mis_acc;
    logic data_ok_v, keep, id_valid, deq;

    always_comb begin
        aligned   = is_aligned(bus.pc_addr);
        credit_ok = (3'(inflight_q) + 3'(buf_count)) < 3'(FETCH_CAP);
        inst_req  = ~reset & bus.pc_valid & ~bus.flush & aligned & credit_ok;
        req_acc   = inst_req & bus.inst_addr_ok;
        // A misaligned fetch only enters once the bus is quiet, so its AdEL
        // entry cannot overtake earlier instructions.
        mis_acc   = ~reset & bus.pc_valid & ~aligned & ~bus.flush
                  & (inflight_q == 2'd0) & (cancel_q == 2'd0)
                  & (buf_count < 2'(FETCH_CAP));
        data_ok_v = ~reset & bus.inst_data_ok & (inflight_q != 2'd0);
        keep      = data_ok_v & (state_q == RUN) & ~bus.flush;
        id_valid  = ~reset & (buf_count != 2'd0) & ~bus.flush;
        deq       = id_valid & bus.id_ready;

        buf_wdata = '0;
        if (keep) begin
            buf_wdata.pc   = pend_head;
            buf_wdata.inst = bus.inst_rdata;
            buf_wdata.adel = 1'b0;
        end else begin
            buf_wdata.pc   = bus.pc_addr;
            buf_wdata.inst = '0;
            buf_wdata.adel = 1'b1;
        end

        inflight_d = inflight_q + 2'(req_acc) - 2'(data_ok_v);
    end

    // Control FSM: cancel counts responses still owed to flushed requests.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        if (bus.flush) begin
            cancel_d = inflight_q - 2'(data_ok_v);
            state_d  = (cancel_d != 2'd0) ? DRAIN : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    state_d = RUN;
                end
                DRAIN: begin
                    if (data_ok_v) begin
                        cancel_d = cancel_q - 2'd1;
                        if (cancel_d == 2'd0) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            inflight_q <= 2'd0;
            cancel_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            cancel_q   <= cancel_d;
        end
    end

    ifetch_fifo #(.WIDTH(32)) u_pend (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .push  (req_acc),
        .wdata (bus.pc_addr),
        .pop   (keep),
        .rdata (pend_head),
        .count (pend_count)
    );

    ifetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_buf (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .push  (keep | mis_acc),
        .wdata (buf_wdata),
        .pop   (deq),
        .rdata (buf_head),
        .count (buf_count)
    );

    assign bus.inst_req  = inst_req;
    assign bus.inst_addr = bus.pc_addr;
    assign bus.pc_ready  = req_acc | mis_acc;
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = buf_head.pc;
    assign bus.id_inst   = buf_head.inst;
    assign bus.id_adel   = buf_head.adel;

    always_ff @(posedge clk) begin
        if (!reset && bus.inst_data_ok) begin
            assert (inflight_q != 2'd0);
        end
        if (!reset && keep) begin
            assert (pend_count != 2'd0);
        end
        if (!reset) begin
            assert ((3'(inflight_q) + 3'(buf_count)) <= 3'(FETCH_CAP));
        end
    end

endmodule

// File: tb/tb_ifetch_bridge.sv
// tb_ifetch_bridge
//   Self-checking bench for ifetch_bridge: a vector table for the main
//   fetch/backpressure/misaligned flow, hand-written flush and reset
//   sequences, and a scoreboard of accepted fetches compared at dequeue.
module tb_ifetch_bridge;
    import ifetch_bridge_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_bridge_if bus();

    ifetch_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        aok;
        logic        rdy;
        logic        req;
        logic        prdy;
        logic        idv;
        logic [31:0] idpc;
        logic [1:0]  nbuf;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic        mem_hold;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[15];

    localparam logic [31:0] PA = 32'hbfc0_0000;
    localparam logic [31:0] PB = 32'hbfc0_0004;
    localparam logic [31:0] PC = 32'hbfc0_0008;
    localparam logic [31:0] PD = 32'hbfc0_000c;
    localparam logic [31:0] PE = 32'hbfc0_0010;
    localparam logic [31:0] PM = 32'hbfc0_0002;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Negedge sampling: memory model bookkeeping and scoreboard.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        if (bus.inst_req && bus.inst_addr_ok) mem_q.push_back(bus.inst_addr);
        if (reset || bus.flush) begin
            exp_q.delete();
        end else begin
            if (bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pc", bus.id_pc, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.id_pc, e.pc);
                    chk("sb_inst", bus.id_inst, e.inst);
                    chk("sb_adel", 32'(bus.id_adel), 32'(e.adel));
                end
            end
            if (bus.pc_ready) begin
                e.pc   = bus.pc_addr;
                e.adel = !is_aligned(bus.pc_addr);
                e.inst = e.adel ? 32'h0 : mem_word(bus.pc_addr);
                exp_q.push_back(e);
            end
        end
    endtask

    // Just after the rising edge: memory returns one response per cycle.
    task automatic advance();
        @(posedge clk);
        #1;
        if (!mem_hold && mem_q.size() > 0) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = mem_word(mem_q.pop_front());
        end else begin
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = '0;
        end
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_inst_req"}, 32'(bus.inst_req), 32'd0);
        chk({tag, "_pc_ready"}, 32'(bus.pc_ready), 32'd0);
        chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, "_id_pc"}, bus.id_pc, 32'd0);
        chk({tag, "_id_inst"}, bus.id_inst, 32'd0);
        chk({tag, "_id_adel"}, 32'(bus.id_adel), 32'd0);
        chk({tag, "_inflight"}, 32'(dut.inflight_q), 32'd0);
        chk({tag, "_buffered"}, 32'(dut.buf_count), 32'd0);
        chk({tag, "_cancel"}, 32'(dut.cancel_q), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(RUN));
    endtask

    task automatic drive_pc(input logic v, input logic [31:0] a);
        bus.pc_valid     = v;
        bus.pc_addr      = a;
        bus.inst_addr_ok = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic got;

        //            pv    pc   aok   rdy   req   prdy  idv   idpc   nbuf
        vecs[0]  = '{1'b1, PA,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0};
        vecs[1]  = '{1'b1, PB,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0};
        vecs[2]  = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PA,    2'd1};
        vecs[3]  = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PB,    2'd1};
        vecs[4]  = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0};
        vecs[5]  = '{1'b1, PC,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0};
        vecs[6]  = '{1'b1, PD,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0};
        vecs[7]  = '{1'b1, PE,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PC,    2'd1};
        vecs[8]  = '{1'b1, PE,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PC,    2'd2};
        vecs[9]  = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PC,    2'd2};
        vecs[10] = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PD,    2'd1};
        vecs[11] = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0};
        vecs[12] = '{1'b1, PM,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0};
        vecs[13] = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PM,    2'd1};
        vecs[14] = '{1'b0, 32'h0,1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0};

        reset            = 1'b1;
        bus.pc_valid     = 1'b0;
        bus.pc_addr      = '0;
        bus.flush        = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        bus.id_ready     = 1'b1;
        mem_hold         = 1'b0;

        advance();
        settle();
        check_idle("rst");
        advance();
        reset = 1'b0;
        settle();
        check_idle("post_rst");
        advance();

        // Back-to-back, backpressure and misaligned fetch.
        for (int i = 0; i < 15; i++) begin
            bus.pc_valid     = vecs[i].pv;
            bus.pc_addr      = vecs[i].pc;
            bus.inst_addr_ok = vecs[i].aok;
            bus.id_ready     = vecs[i].rdy;
            settle();
            chk($sformatf("v%0d_inst_req", i), 32'(bus.inst_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_pc_ready", i), 32'(bus.pc_ready), 32'(vecs[i].prdy));
            chk($sformatf("v%0d_id_valid", i), 32'(bus.id_valid), 32'(vecs[i].idv));
            chk($sformatf("v%0d_buffered", i), 32'(dut.buf_count), 32'(vecs[i].nbuf));
            if (vecs[i].idv) chk($sformatf("v%0d_id_pc", i), bus.id_pc, vecs[i].idpc);
            advance();
        end

        // id_valid masked in the flush cycle and the cycle after.
        bus.id_ready = 1'b0;
        drive_pc(1'b1, PA);
        cyc();
        drive_pc(1'b0, 32'h0);
        cyc();
        settle();
        chk("fl0_id_valid_before", 32'(bus.id_valid), 32'd1);
        advance();
        bus.flush    = 1'b1;
        bus.id_ready = 1'b1;
        settle();
        chk("fl0_id_valid_flush", 32'(bus.id_valid), 32'd0);
        advance();
        bus.flush = 1'b0;
        settle();
        chk("fl0_id_valid_after", 32'(bus.id_valid), 32'd0);
        chk("fl0_buffered", 32'(dut.buf_count), 32'd0);
        advance();

        // Flush with two in flight; both responses dropped, EXEC_ADDR kept.
        mem_hold = 1'b1;
        drive_pc(1'b1, PA);
        settle();
        chk("fl2_acc_a", 32'(bus.pc_ready), 32'd1);
        advance();
        drive_pc(1'b1, PB);
        settle();
        chk("fl2_acc_b", 32'(bus.pc_ready), 32'd1);
        advance();
        drive_pc(1'b0, 32'h0);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        drive_pc(1'b1, EXEC_ADDR);
        settle();
        chk("fl2_cancel", 32'(dut.cancel_q), 32'd2);
        chk("fl2_state", 32'(dut.state_q), 32'(DRAIN));
        chk("fl2_no_credit", 32'(bus.inst_req), 32'd0);
        advance();
        mem_hold = 1'b0;
        advance();
        settle();
        chk("fl2_drop1_id_valid", 32'(bus.id_valid), 32'd0);
        advance();
        settle();
        chk("fl2_cancel_after1", 32'(dut.cancel_q), 32'd1);
        chk("fl2_exec_req", 32'(bus.pc_ready), 32'd1);
        advance();
        drive_pc(1'b0, 32'h0);
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            settle();
            if (bus.id_valid) begin
                got = 1'b1;
                chk("fl2_exec_pc", bus.id_pc, EXEC_ADDR);
            end
            advance();
        end
        chk("fl2_exec_delivered", 32'(got), 32'd1);
        chk("fl2_state_run", 32'(dut.state_q), 32'(RUN));

        // Flush coinciding with the only response.
        drive_pc(1'b1, PA);
        cyc();
        drive_pc(1'b0, 32'h0);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        settle();
        chk("fl1_cancel", 32'(dut.cancel_q), 32'd0);
        chk("fl1_state", 32'(dut.state_q), 32'(RUN));
        chk("fl1_inflight", 32'(dut.inflight_q), 32'd0);
        advance();
        for (int n = 0; n < 3; n++) begin
            settle();
            chk($sformatf("fl1_id_valid_%0d", n), 32'(bus.id_valid), 32'd0);
            advance();
        end

        // Reset with two outstanding; stale response during reset ignored.
        mem_hold = 1'b1;
        drive_pc(1'b1, PA);
        cyc();
        drive_pc(1'b1, PB);
        cyc();
        drive_pc(1'b0, 32'h0);
        chk("rst2_inflight_before", 32'(dut.inflight_q), 32'd2);
        reset            = 1'b1;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hdead_beef;
        mem_q.delete();
        cyc();
        reset    = 1'b0;
        mem_hold = 1'b0;
        settle();
        check_idle("rst2");
        advance();
        for (int n = 0; n < 2; n++) begin
            settle();
            chk($sformatf("rst2_id_valid_%0d", n), 32'(bus.id_valid), 32'd0);
            advance();
        end

        // Recovery fetch after reset.
        drive_pc(1'b1, RESET_ADDR);
        cyc();
        drive_pc(1'b0, 32'h0);
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            settle();
            if (bus.id_valid) begin
                got = 1'b1;
                chk("rec_pc", bus.id_pc, RESET_ADDR);
            end
            advance();
        end
        chk("rec_delivered", 32'(got), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_bridge.md
IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
- REQ-001 The block SHALL have no parameters; the in-flight/buffer capacity SHALL be fixed at 2.
- REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 pc_addr  input  32  next fetch address from the PC stage (its npc).
- REQ-005 pc_valid  input  1  pc_addr is valid this cycle.
- REQ-006 pc_ready  output  1  pc_addr accepted this cycle; the PC stage SHALL treat its inverse as stall.
- REQ-007 flush  input  1  redirect (exception, eret, mispredict); discard all fetches in flight or buffered.
- REQ-008 inst_req  output  1  SRAM-like instruction request.
- REQ-009 inst_addr  output  32  request address, always equal to pc_addr.
- REQ-010 inst_addr_ok  input  1  request accepted by memory.
- REQ-011 inst_data_ok  input  1  one read response valid, returned in request order.
- REQ-012 inst_rdata  input  32  response data.
- REQ-013 id_valid  output  1  instruction available to decode.
- REQ-014 id_ready  input  1  decode consumes the head entry.
- REQ-015 id_pc  output  32  address of the head entry.
- REQ-016 id_inst  output  32  instruction word of the head entry.
- REQ-017 id_adel  output  1  the head entry is a misaligned fetch (AdEL).

Function
- REQ-018 Credit: inflight (0..2) + buffered (0..2) SHALL never exceed 2.
- REQ-019 inst_req SHALL be pc_valid & ~flush & pc_addr[1:0]==0 & (inflight+buffered<2).
- REQ-020 pc_ready SHALL be inst_req & inst_addr_ok, or the misaligned accept of REQ-021.
- REQ-021 Misaligned pc_addr: no bus request; accept only when inflight==0, cancel==0, buffered<2 and ~flush; enqueue {pc_addr, inst=0, adel=1}.
- REQ-022 Each accepted request SHALL push pc_addr into a 2-entry pending-address queue; each kept data_ok SHALL pop it and enqueue {pc, inst_rdata, adel=0} into the 2-entry output buffer.
- REQ-023 Latency: id_valid SHALL rise the cycle after the enqueueing data_ok (registered output, no bypass).
- REQ-024 A dequeue happens when id_valid & id_ready; simultaneous enqueue and dequeue SHALL be allowed when full.
- REQ-025 Control FSM states: RUN (cancel==0) and DRAIN (cancel>0).
- REQ-026 On flush, the output buffer and pending queue SHALL clear, and cancel SHALL load with inflight minus (1 if data_ok that same cycle, else 0); the next state SHALL be DRAIN if that value is >0, else RUN.
- REQ-027 In DRAIN, each data_ok SHALL be dropped and decrement cancel; on reaching 0 the state SHALL return to RUN.
- REQ-028 New requests SHALL be permitted in DRAIN when credit allows, and their responses SHALL be kept only after cancel reaches 0.
- REQ-029 id_valid SHALL be 0 in the flush cycle and in the cycle after it.
- REQ-030 A data_ok with inflight==0 SHALL be ignored (protocol error; assertion in simulation).

Reset
- REQ-031 On reset: inst_req=0, pc_ready=0, id_valid=0, id_adel=0, id_pc=0, id_inst=0, inflight=0, buffered=0, cancel=0, state=RUN.
- REQ-032 Reset during outstanding requests SHALL discard them; memory is reset by the same signal.

Structure
- REQ-033 The shared defines header SHALL hold the fetch capacity (2) and the AdEL code; the existing RESET_ADDR/EXEC_ADDR defines SHALL stay there.
- REQ-034 One sub-module, ifetch_fifo (2-entry, width-parameterised, sync clear), SHALL implement both the pending queue and the output buffer.

Verification
- REQ-035 Back-to-back: pc 0xbfc00000, 0xbfc00004, addr_ok=1, data_ok 1 cycle later -> id_valid each cycle, id_pc in order, pc_ready stays high.
- REQ-036 Backpressure: id_ready=0, two responses -> buffered=2, inst_req=0, pc_ready=0; id_ready=1 -> the 0xbfc00000 entry pops first.
- REQ-037 Flush with 2 in flight -> cancel=2; the next two data_ok are dropped; the request to 0xbfc00380 is kept and delivered.
- REQ-038 Flush in the same cycle as data_ok with inflight=1 -> cancel=0, state RUN, no entry delivered.
- REQ-039 pc_addr=0xbfc00002 -> no inst_req; id_adel=1, id_inst=0, id_pc=0xbfc00002.
- REQ-040 Reset asserted with inflight=2 -> all outputs 0 the next cycle and a stale data_ok is ignored.
